// File: rtl/fm_voice_router.sv
// fm_voice_router
//     Per-voice glue between the host parameter bus and an array of N_OPS
//     operators. It holds double-buffered per-operator configuration, routes
//     modulation between operators, and mixes the operator outputs into one
//     saturated sample, one operator per clock.
//
// Ports
//     clk24         system clock
//     rst_n         asynchronous active-low reset
//     sample_en     one-cycle strobe per audio sample
//     write         parameter write strobe (lands in the shadow bank)
//     addr          parameter address
//     param         parameter data
//     commit        request a shadow->active copy at the next accepted sample
//     op_out_bus    operator outputs, op i at [i*W +: W]
//     op_modin_bus  registered modulation input per operator
//     op_amp_bus    active amplitude per operator
//     sound_output  mixed, shifted, saturated sample
//     sample_valid  one-cycle pulse when sound_output updates
//     busy          mixer is accumulating or presenting a sample
//     overrun       sticky: a sample_en arrived while busy
module fm_voice_router #(
    parameter int N_OPS = 6,
    parameter int W     = 16,
    parameter int PW    = 32,
    parameter int AW    = 6
) (
    input  logic               clk24,
    input  logic               rst_n,
    input  logic               sample_en,
    input  logic               write,
    input  logic [AW-1:0]      addr,
    input  logic [PW-1:0]      param,
    input  logic               commit,
    input  logic [N_OPS*W-1:0] op_out_bus,
    output logic [N_OPS*W-1:0] op_modin_bus,
    output logic [N_OPS*W-1:0] op_amp_bus,
    output logic [W-1:0]       sound_output,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int SW    = $clog2(N_OPS + 1);
    localparam int ACC_W = W + SW;
    localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t                   r_state, w_next;
    logic [W-1:0]             r_sh_amp     [N_OPS];
    logic [W-1:0]             r_act_amp    [N_OPS];
    logic [SW-1:0]            r_sh_modsel  [N_OPS];
    logic [SW-1:0]            r_act_modsel [N_OPS];
    logic [N_OPS-1:0]         r_sh_mask, r_act_mask, r_smp_mask;
    logic [3:0]               r_sh_shift, r_act_shift, r_smp_shift;
    logic                     r_pending;
    logic [W-1:0]             r_snap       [N_OPS];
    logic [SW-1:0]            r_idx;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [W-1:0]             r_sound;
    logic                     r_valid;
    logic                     r_overrun;
    logic [N_OPS*W-1:0]       r_modin_p1, w_modin;
    logic                     w_start, w_take, w_clr;
    logic                     w_unused_param;

    function automatic logic [W-1:0] sat_w(input logic signed [ACC_W-1:0] v);
        if (v > C_MAX)
            return {1'b0, {(W-1){1'b1}}};
        else if (v < C_MIN)
            return {1'b1, {(W-1){1'b0}}};
        else
            return v[W-1:0];
    endfunction

    assign w_unused_param = ^param;
    assign w_start = (r_state == S_IDLE) && sample_en;
    // The shadow copy rides on the sample_en that starts a sample; a strobe
    // ignored while busy leaves the request pending.
    assign w_take  = w_start && r_pending;
    assign w_clr   = write && (addr == AW'(2 * N_OPS + 2));

    // ---- parameter banks ----
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OPS; i++) begin
                r_sh_amp[i]     <= '0;
                r_act_amp[i]    <= '0;
                r_sh_modsel[i]  <= '0;
                r_act_modsel[i] <= '0;
            end
            r_sh_mask   <= '0;
            r_act_mask  <= '0;
            r_sh_shift  <= '0;
            r_act_shift <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (write) begin
                for (int i = 0; i < N_OPS; i++) begin
                    if (addr == AW'(i))
                        r_sh_amp[i] <= param[W-1:0];
                    if (addr == AW'(N_OPS + i))
                        r_sh_modsel[i] <= param[SW-1:0];
                end
                if (addr == AW'(2 * N_OPS))
                    r_sh_mask <= param[N_OPS-1:0];
                if (addr == AW'(2 * N_OPS + 1))
                    r_sh_shift <= param[3:0];
            end
            if (w_take) begin
                for (int i = 0; i < N_OPS; i++) begin
                    r_act_amp[i]    <= r_sh_amp[i];
                    r_act_modsel[i] <= r_sh_modsel[i];
                end
                r_act_mask  <= r_sh_mask;
                r_act_shift <= r_sh_shift;
                r_pending   <= 1'b0;
            end else if (commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    // ---- modulation routing (1-cycle latency) ----
    always_comb begin
        w_modin = '0;
        for (int i = 0; i < N_OPS; i++)
            for (int k = 0; k < N_OPS; k++)
                if (r_act_modsel[i] == SW'(k + 1))
                    w_modin[i*W +: W] = op_out_bus[k*W +: W];
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n)
            r_modin_p1 <= '0;
        else
            r_modin_p1 <= w_modin;
    end

    // ---- mixer FSM ----
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_en) w_next = S_ACC;
            S_ACC:   if (r_idx == SW'(N_OPS - 1)) w_next = S_OUT;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_term = '0;
        for (int k = 0; k < N_OPS; k++)
            if (r_idx == SW'(k) && r_smp_mask[k])
                w_term = {{SW{r_snap[k][W-1]}}, r_snap[k]};
    end

    assign w_shifted = r_acc >>> r_smp_shift;

    // ---- mixer datapath ----
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OPS; k++)
                r_snap[k] <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_smp_mask  <= '0;
            r_smp_shift <= '0;
            r_sound     <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sample_en) begin
                        for (int k = 0; k < N_OPS; k++)
                            r_snap[k] <= op_out_bus[k*W +: W];
                        r_acc <= '0;
                        r_idx <= '0;
                        // A commit consumed on this strobe already applies
                        // to this sample, so pick the shadow values directly.
                        r_smp_mask  <= r_pending ? r_sh_mask  : r_act_mask;
                        r_smp_shift <= r_pending ? r_sh_shift : r_act_shift;
                    end
                end
                S_ACC: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + 1'b1;
                end
                S_OUT: begin
                    r_sound <= sat_w(w_shifted);
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n)
            r_overrun <= 1'b0;
        else if (sample_en && (r_state != S_IDLE))
            r_overrun <= 1'b1;
        else if (w_clr)
            r_overrun <= 1'b0;
    end

    for (genvar g = 0; g < N_OPS; g++) begin : g_amp
        assign op_amp_bus[g*W +: W] = r_act_amp[g];
    end

    assign op_modin_bus = r_modin_p1;
    assign sound_output = r_sound;
    assign sample_valid = r_valid;
    assign busy         = (r_state != S_IDLE);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_fm_voice_router.sv
// tb_fm_voice_router
//     Directed bench for fm_voice_router with N_OPS=6, W=16: reset state,
//     shadow/active banking, mixer latency and saturation, routing, overrun,
//     and reset during accumulation.
module tb_fm_voice_router;

    localparam int N  = 6;
    localparam int W  = 16;
    localparam int PW = 32;
    localparam int AW = 6;

    logic           clk24 = 1'b0;
    logic           rst_n = 1'b0;
    logic           sample_en = 1'b0;
    logic           write = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic [PW-1:0]  param = '0;
    logic           commit = 1'b0;
    logic [N*W-1:0] op_out_bus = '0;
    logic [N*W-1:0] op_modin_bus;
    logic [N*W-1:0] op_amp_bus;
    logic [W-1:0]   sound_output;
    logic           sample_valid;
    logic           busy;
    logic           overrun;

    int n_chk  = 0;
    int n_pass = 0;

    fm_voice_router #(.N_OPS(N), .W(W), .PW(PW), .AW(AW)) u_dut (
        .clk24        (clk24),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .write        (write),
        .addr         (addr),
        .param        (param),
        .commit       (commit),
        .op_out_bus   (op_out_bus),
        .op_modin_bus (op_modin_bus),
        .op_amp_bus   (op_amp_bus),
        .sound_output (sound_output),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk24 = ~clk24;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk24);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        write = 1'b1;
        addr  = AW'(a);
        param = d;
        tick();
        write = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int i = 0; i < N; i++)
            op_out_bus[i*W +: W] = v;
    endtask

    task automatic run_sample(output int lat, output logic [15:0] res);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        lat = 99;
        res = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (sample_valid) begin
                lat = c;
                res = sound_output;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        int          npulse;
        logic [15:0] res;

        // reset and idle
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("rst_sound", 32'(sound_output), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_amp_or", 32'(|op_amp_bus), 32'h0);
        check("rst_modin_or", 32'(|op_modin_bus), 32'h0);

        // shadow writes are invisible until commit + sample_en
        for (int i = 0; i < N; i++)
            wr(i, 32'(256 * (i + 1)));
        run_sample(lat, res);
        check("nocommit_amp_or", 32'(|op_amp_bus), 32'h0);
        do_commit();
        check("pending_amp_or", 32'(|op_amp_bus), 32'h0);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        for (int i = 0; i < N; i++)
            check("commit_amp", 32'(op_amp_bus[i*W +: W]), 32'(256 * (i + 1)));
        repeat (10) tick();

        // mixer: sum, latency, saturation, shift
        wr(12, 32'h3F);
        wr(13, 32'h0);
        do_commit();
        set_all(16'h1000);
        run_sample(lat, res);
        check("mix_latency", 32'(lat), 32'd7);
        check("mix_sum_1000", 32'(res), 32'h6000);
        check("mix_busy_done", 32'(busy), 32'h0);

        set_all(16'h7000);
        run_sample(lat, res);
        check("sat_pos", 32'(res), 32'h7FFF);
        set_all(16'h9000);
        run_sample(lat, res);
        check("sat_neg", 32'(res), 32'h8000);
        wr(13, 32'h3);
        do_commit();
        set_all(16'h7000);
        run_sample(lat, res);
        check("shift3", 32'(res), 32'h5400);

        // partial mask: ops 0 and 2 only -> 0x100 + 0x300
        wr(12, 32'h05);
        wr(13, 32'h0);
        do_commit();
        for (int i = 0; i < N; i++)
            op_out_bus[i*W +: W] = 16'(256 * (i + 1));
        run_sample(lat, res);
        check("mask_05", 32'(res), 32'h0400);

        // routing
        wr(8, 32'd4);
        wr(9, 32'd7);
        do_commit();
        run_sample(lat, res);
        for (int i = 0; i < N; i++)
            op_out_bus[i*W +: W] = 16'(16'h1100 * (i + 1));
        tick();
        check("route_2_from_3", 32'(op_modin_bus[2*W +: W]), 32'h4400);
        check("route_3_oob", 32'(op_modin_bus[3*W +: W]), 32'h0);
        check("route_0_zero", 32'(op_modin_bus[0*W +: W]), 32'h0);
        op_out_bus[3*W +: W] = 16'hABCD;
        #1;
        check("route_registered", 32'(op_modin_bus[2*W +: W]), 32'h4400);
        tick();
        check("route_update", 32'(op_modin_bus[2*W +: W]), 32'hABCD);

        // overrun, snapshot isolation, pending commit survives ignored strobe
        wr(12, 32'h3F);
        do_commit();
        set_all(16'h0100);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        set_all(16'h2000);
        write  = 1'b1;
        addr   = AW'(0);
        param  = 32'h1234;
        commit = 1'b1;
        tick();
        write  = 1'b0;
        commit = 1'b0;
        tick();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        check("overrun_set", 32'(overrun), 32'h1);
        npulse = 0;
        res = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (sample_valid) begin
                npulse++;
                res = sound_output;
            end
        end
        check("overrun_pulses", 32'(npulse), 32'd1);
        check("snapshot_sum", 32'(res), 32'h0600);
        check("overrun_sticky", 32'(overrun), 32'h1);
        check("pending_kept_amp0", 32'(op_amp_bus[0 +: W]), 32'h0100);
        wr(14, 32'h0);
        check("overrun_clear", 32'(overrun), 32'h0);
        run_sample(lat, res);
        check("pending_applied_amp0", 32'(op_amp_bus[0 +: W]), 32'h1234);
        check("sat_c000", 32'(res), 32'h7FFF);

        // async reset during accumulation
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        tick();
        check("midacc_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_amp0", 32'(op_amp_bus[0 +: W]), 32'h0);
        tick();
        rst_n = 1'b1;
        npulse = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (sample_valid)
                npulse++;
        end
        check("async_rst_no_valid", 32'(npulse), 32'd0);
        check("async_rst_sound", 32'(sound_output), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
